// File: rtl/dwt_haar_ml_if.sv
// Stream bundle for the multi-level Haar DWT.
// Sample input side plus per-level coefficient outputs.
interface dwt_haar_ml_if #(
   parameter int DATA_W = 8,
   parameter int LEVELS = 3
);
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_last;
   logic [LEVELS-1:0]        det_valid;
   logic [LEVELS*DATA_W-1:0] det_data;
   logic                     app_valid;
   logic [DATA_W-1:0]        app_data;
   logic                     app_last;
   logic                     frame_err;

   modport master (
      output in_valid, in_data, in_last,
      input  det_valid, det_data, app_valid, app_data, app_last, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output det_valid, det_data, app_valid, app_data, app_last, frame_err
   );
endinterface

// File: rtl/dwt_haar_ml.sv
// Streaming multi-level Haar DWT: cascaded average/difference stages.
// Each level pairs the previous level's averages; a bad in_last flushes all.
module dwt_haar_ml #(
   parameter int DATA_W = 8,
   parameter int LEVELS = 3
) (
   input  logic clk,
   input  logic rst_n,
   dwt_haar_ml_if.slave io
);
   localparam logic [LEVELS-1:0] CNT_MAX = '1;

   logic [LEVELS-1:0]        cnt;
   logic                     err;
   logic                     frame_err_r;

   logic [LEVELS-1:0]        phase;
   logic [LEVELS-1:0]        vld;
   logic [LEVELS-1:0]        lst;
   logic [DATA_W-1:0]        held  [LEVELS];
   logic [DATA_W-1:0]        avg_r [LEVELS];
   logic [DATA_W-1:0]        det_r [LEVELS];

   logic [LEVELS-1:0]        op_v;
   logic [LEVELS-1:0]        op_l;
   logic [DATA_W-1:0]        op_d  [LEVELS];
   logic signed [DATA_W:0]   sum_w [LEVELS];
   logic signed [DATA_W:0]   dif_w [LEVELS];
   logic [DATA_W-1:0]        avg_n [LEVELS];
   logic [DATA_W-1:0]        det_n [LEVELS];
   logic [LEVELS*DATA_W-1:0] det_flat;

   // Misaligned frame end: in_last on a sample that is not last in its group
   always_comb begin
      err = io.in_valid & io.in_last & (cnt != CNT_MAX);
   end

   // Operand feed per level: raw samples into level 1, averages onward
   always_comb begin
      op_v[0] = io.in_valid & ~err;
      op_l[0] = io.in_last;
      op_d[0] = io.in_data;
      for (int k = 1; k < LEVELS; k++) begin
         op_v[k] = vld[k-1];
         op_l[k] = lst[k-1];
         op_d[k] = avg_r[k-1];
      end
   end

   // Pair arithmetic one bit wider, floor shift, then truncate back
   always_comb begin
      for (int k = 0; k < LEVELS; k++) begin
         sum_w[k] = $signed({held[k][DATA_W-1], held[k]})
                  + $signed({op_d[k][DATA_W-1], op_d[k]});
         dif_w[k] = $signed({held[k][DATA_W-1], held[k]})
                  - $signed({op_d[k][DATA_W-1], op_d[k]});
         avg_n[k] = DATA_W'(sum_w[k] >>> 1);
         det_n[k] = DATA_W'(dif_w[k] >>> 1);
      end
   end

   // Group position counter, restarted by reset or a framing error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (err) begin
         cnt <= '0;
      end else if (io.in_valid) begin
         cnt <= cnt + LEVELS'(1);
      end
   end

   // Per-level pairing: hold operand a, combine with b and register result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase       <= '0;
         vld         <= '0;
         lst         <= '0;
         frame_err_r <= 1'b0;
         for (int k = 0; k < LEVELS; k++) begin
            held[k]  <= '0;
            avg_r[k] <= '0;
            det_r[k] <= '0;
         end
      end else begin
         vld         <= '0;
         lst         <= '0;
         frame_err_r <= err;
         if (err) begin
            phase <= '0;
            for (int k = 0; k < LEVELS; k++) begin
               held[k] <= '0;
            end
         end else begin
            for (int k = 0; k < LEVELS; k++) begin
               if (op_v[k]) begin
                  if (phase[k]) begin
                     phase[k] <= 1'b0;
                     vld[k]   <= 1'b1;
                     lst[k]   <= op_l[k];
                     avg_r[k] <= avg_n[k];
                     det_r[k] <= det_n[k];
                  end else begin
                     phase[k] <= 1'b1;
                     held[k]  <= op_d[k];
                  end
               end
            end
         end
      end
   end

   // Pack per-level detail registers into the flat output bus
   always_comb begin
      det_flat = '0;
      for (int k = 0; k < LEVELS; k++) begin
         det_flat[k*DATA_W +: DATA_W] = det_r[k];
      end
   end

   assign io.det_valid = vld;
   assign io.det_data  = det_flat;
   assign io.app_valid = vld[LEVELS-1];
   assign io.app_data  = avg_r[LEVELS-1];
   assign io.app_last  = lst[LEVELS-1];
   assign io.frame_err = frame_err_r;
endmodule

// File: doc/dwt_haar_ml.md
Name: dwt_haar_ml

Overview:
Parametrised multi-level streaming Haar DWT for EEG compression. It is the successor to the single-level dwt pair block. It accepts one signed sample per cycle and cascades LEVELS pairwise average/difference stages, where each stage consumes the previous stage's averages. It emits per-level detail coefficients plus the final approximation to the downstream RLE encoder, with frame-boundary checking.

Parameters:
DATA_W, 8, signed sample and coefficient width (all outputs also DATA_W).
LEVELS, 3, number of decomposition levels, legal range 1..4; a frame group is 2^LEVELS samples.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  in_data/in_last are valid this cycle; no backpressure
in_data  in  DATA_W  signed input sample
in_last  in  1  marks the final sample of a frame
det_valid  out  LEVELS  bit k-1: level-k detail coefficient valid
det_data  out  LEVELS*DATA_W  slice [k*DATA_W-1:(k-1)*DATA_W] holds the level-k detail
app_valid  out  1  final-level approximation valid
app_data  out  DATA_W  final-level approximation
app_last  out  1  with app_valid: this approximation closes the frame
frame_err  out  1  one-cycle pulse on a misaligned in_last

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge. While rst_n=0 at an edge, all outputs go to 0 (det_valid, det_data, app_valid, app_data, app_last, frame_err), along with the group counter, per-level held operand, per-level phase bit and all in-flight pipeline valids. Reset mid-frame discards partial pairs; the first sample after reset is the first of a new group.
- Stage arithmetic (level k, operands a = first, b = second of a pair):
  - avg = (a+b)>>>1
  - det = (a-b)>>>1
  - Both are computed at DATA_W+1 bits, arithmetic right shift (floor), then truncated to DATA_W. The results always fit, so no saturation logic is needed.
- Pairing: each level keeps a phase bit and a held operand. On a valid operand with phase=0, store it as a and set phase=1. With phase=1, compute with b, clear phase, and register the result.
- Timing: level 1 registers its outputs at the edge that captures sample b, so det_valid[0] is high the cycle after in_valid of b. Level k's result is registered one edge after level k-1's average is registered. Level k latency is therefore k cycles after the completing input sample. app_valid/app_data coincide exactly with det_valid[LEVELS-1].
- All valids are single-cycle pulses, and data holds its last value when valid=0. in_valid low does not stall the pipeline: in-flight averages keep advancing, and gaps of any length between samples are legal.
- Group counter: LEVELS bits, increments on every in_valid and wraps at 2^LEVELS-1 -> 0.
- in_last with group counter = 2^LEVELS-1 is a normal frame end. The flag propagates with the group and sets app_last together with that group's app_valid.
- in_last with group counter != 2^LEVELS-1 is an error:
  - The sample is discarded.
  - frame_err pulses the next cycle.
  - The group counter, all phase bits, held operands and all in-flight pipeline valids clear at that edge.
  - No det_valid/app_valid fires for the next LEVELS cycles.
  - The next valid sample starts a fresh group.
- in_last with in_valid=0 is ignored.
- Frames need not end with in_last. Continuous streaming simply wraps groups.

Test Plan:
1. DATA_W=8, LEVELS=2; samples 10,20,30,50, in_last on 50 -> L1 det -5 (1 cycle after 20), L1 det -10 (1 cycle after 50), then L2 det -13, app_data 27 and app_last=1, 2 cycles after 50.
2. Extremes, LEVELS=1: pair 127,-128 -> avg -1, det 127; pair -128,127 -> avg -1, det -128; no overflow.
3. LEVELS=2; samples 1,2,3 with in_last on 3 -> frame_err=1 one cycle later, no det/app pulses for 2 cycles; then 4,4,4,4 -> all dets 0, app_data 4.
4. LEVELS=2; ramp 0..7 continuous -> L1 dets all -1; L2 dets -1,-1; approximations 1 then 5; app_last=0.
5. Repeat scenario 1 with in_valid asserted only every third cycle -> identical coefficient values, each at its completing-sample latency.
6. LEVELS=2; samples 9,9 then rst_n=0 for one cycle, then 2,4,6,8 -> all outputs 0 during reset; no output derived from 9,9 after reset; results L1 dets -1,-1, L2 det -2, app 5.
